// File: rtl/mux4.sv
// rtl/mux4.sv - next-PC select mux with registered PC and taken-branch counter
//
// Purpose:
//   Selects the next PC from the sequential and branch-target candidates.
//   The selected value is exposed combinationally. It is also committed into
//   a PC register under a write enable. Each committed taken branch advances
//   a saturating counter.
//
// Ports:
//   clk         in   1      rising-edge clock for pc_q / branch_cnt
//   rst_n       in   1      asynchronous active-low reset of registered state
//   adder1_out  in   WIDTH  sequential next-PC candidate (PC+4)
//   adder2_out  in   WIDTH  branch-target next-PC candidate
//   AndGateOut  in   1      branch taken: 1 selects adder2_out, 0 adder1_out
//   pc_we       in   1      PC register write enable
//   pc_in       out  WIDTH  combinational selected next PC
//   pc_q        out  WIDTH  registered PC
//   branch_cnt  out  CNT_W  saturating count of committed taken branches
//   misaligned  out  1      combinational: pc_in low two bits non-zero

module mux4 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] adder1_out,
  input  logic [WIDTH-1:0] adder2_out,
  input  logic             AndGateOut,
  input  logic             pc_we,
  output logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_q,
  output logic [CNT_W-1:0] branch_cnt,
  output logic             misaligned
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // A case statement rather than ?: so that an unknown select drives the
  // whole bus to X instead of merging the candidates bitwise.
  always_comb begin
    pc_in = '0;
    case (AndGateOut)
      1'b0:    pc_in = adder1_out;
      1'b1:    pc_in = adder2_out;
      default: pc_in = 'x;
    endcase
  end

  // Informational only; misaligned targets are still committed.
  assign misaligned = (pc_in[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      branch_cnt <= '0;
    end else if (pc_we) begin
      pc_q <= pc_in;
      // Saturate rather than wrap so an overflowed count never reads small.
      if (AndGateOut && (branch_cnt != CNT_MAX)) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux4.sv
// tb/tb_mux4.sv - self-checking scoreboard bench for mux4

module tb_mux4;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] adder1_out;
  logic [WIDTH-1:0] adder2_out;
  logic             AndGateOut;
  logic             pc_we;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] pc_q;
  logic [CNT_W-1:0] branch_cnt;
  logic             misaligned;

  mux4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adder1_out (adder1_out),
    .adder2_out (adder2_out),
    .AndGateOut (AndGateOut),
    .pc_we      (pc_we),
    .pc_in      (pc_in),
    .pc_q       (pc_q),
    .branch_cnt (branch_cnt),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic             mis;
  } comb_exp_t;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [CNT_W-1:0] cnt;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];
  comb_exp_t ce;
  reg_exp_t  re;

  logic [WIDTH-1:0] m_pc;
  logic [CNT_W-1:0] m_cnt;

  int checks;
  int errors;

  // Drives one cycle of stimulus and pushes the combinational expectation
  // and the register expectation for the following clock edge.
  task automatic apply(input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] a2,
                       input logic sel, input logic we);
    logic [WIDTH-1:0] exp_pc;
    adder1_out = a1;
    adder2_out = a2;
    AndGateOut = sel;
    pc_we      = we;
    exp_pc = sel ? a2 : a1;
    comb_q.push_back('{pc: exp_pc, mis: (exp_pc[1:0] != 2'b00)});
    if (rst_n && we) begin
      m_pc = exp_pc;
      if (sel && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
    end
    reg_q.push_back('{pc: m_pc, cnt: m_cnt});
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    adder1_out = 32'h0000_0010;
    adder2_out = 32'h0000_0022;
    AndGateOut = 1'b1;
    pc_we      = 1'b1;
    #2;
    rst_n = 1'b0;
    m_pc  = '0;
    m_cnt = '0;
    #1;
    checks++;
    if (pc_q !== 32'h0 || branch_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_async pc_q=%h cnt=%h required 0/0", pc_q, branch_cnt);
    end
    checks++;
    if (pc_in !== 32'h0000_0022 || misaligned !== 1'b1) begin
      errors++;
      $display("FAIL reset_comb pc_in=%h mis=%b required 00000022/1", pc_in, misaligned);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc_q !== 32'h0 || branch_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_hold pc_q=%h cnt=%h required 0/0", pc_q, branch_cnt);
    end
    pc_we = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_comb_select;
    logic [WIDTH-1:0] t_a1[8];
    logic [WIDTH-1:0] t_a2[8];
    logic             t_sel[8];
    t_a1 = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'h1234_5678, 32'h8000_0003, 32'h0000_0004, 32'hDEAD_BEEF};
    t_a2 = '{32'h1, 32'h1, 32'hAAAA_AAAA, 32'hAAAA_AAAA,
             32'h0BAD_F00D, 32'h7FFF_FFFC, 32'h0000_0102, 32'hCAFE_F00C};
    t_sel = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      apply(t_a1[i], t_a2[i], t_sel[i], 1'b0);
      #1;
      ce = comb_q.pop_front();
      checks++;
      if (pc_in !== ce.pc || misaligned !== ce.mis) begin
        errors++;
        $display("FAIL comb_sel[%0d] pc_in=%h mis=%b required %h/%b",
                 i, pc_in, misaligned, ce.pc, ce.mis);
      end
      @(posedge clk);
      #1;
      re = reg_q.pop_front();
      checks++;
      if (pc_q !== re.pc || branch_cnt !== re.cnt) begin
        errors++;
        $display("FAIL comb_hold[%0d] pc_q=%h cnt=%h required %h/%h",
                 i, pc_q, branch_cnt, re.pc, re.cnt);
      end
    end
  endtask

  // First edge after reset commits 0x40 as a taken branch, three edges with
  // pc_we low hold, then a misaligned sequential address still loads.
  task automatic test_load_hold;
    logic [WIDTH-1:0] t_a1[5];
    logic [WIDTH-1:0] t_a2[5];
    logic             t_sel[5];
    logic             t_we[5];
    t_a1 = '{32'h44, 32'h50, 32'h60, 32'h70, 32'h43};
    t_a2 = '{32'h40, 32'h80, 32'h90, 32'hA0, 32'hB0};
    t_sel = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    t_we  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      apply(t_a1[i], t_a2[i], t_sel[i], t_we[i]);
      #1;
      ce = comb_q.pop_front();
      checks++;
      if (pc_in !== ce.pc || misaligned !== ce.mis) begin
        errors++;
        $display("FAIL load_comb[%0d] pc_in=%h mis=%b required %h/%b",
                 i, pc_in, misaligned, ce.pc, ce.mis);
      end
      @(posedge clk);
      #1;
      re = reg_q.pop_front();
      checks++;
      if (pc_q !== re.pc || branch_cnt !== re.cnt) begin
        errors++;
        $display("FAIL load_hold[%0d] pc_q=%h cnt=%h required %h/%h",
                 i, pc_q, branch_cnt, re.pc, re.cnt);
      end
    end
  endtask

  task automatic test_saturation;
    #2;
    rst_n = 1'b0;
    m_pc  = '0;
    m_cnt = '0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      apply(32'h4, 32'h40 + 32'(i[3:0]) * 4, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      ce = comb_q.pop_front();
      re = reg_q.pop_front();
      checks++;
      if (pc_q !== re.pc || branch_cnt !== re.cnt) begin
        errors++;
        $display("FAIL saturate[%0d] pc_q=%h cnt=%h required %h/%h",
                 i, pc_q, branch_cnt, re.pc, re.cnt);
      end
    end
    checks++;
    if (branch_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate_final cnt=%h required ffff", branch_cnt);
    end
  endtask

  task automatic test_async_reset;
    apply(32'h8, 32'h40, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    ce = comb_q.pop_front();
    re = reg_q.pop_front();
    checks++;
    if (pc_q !== 32'h40) begin
      errors++;
      $display("FAIL arst_preload pc_q=%h required 00000040", pc_q);
    end
    #2;
    rst_n = 1'b0;
    m_pc  = '0;
    m_cnt = '0;
    #1;
    checks++;
    if (pc_q !== 32'h0 || branch_cnt !== 16'h0) begin
      errors++;
      $display("FAIL arst_clear pc_q=%h cnt=%h required 0/0", pc_q, branch_cnt);
    end
    adder1_out = 32'h0000_0123;
    AndGateOut = 1'b0;
    #1;
    checks++;
    if (pc_in !== 32'h0000_0123 || misaligned !== 1'b1) begin
      errors++;
      $display("FAIL arst_track pc_in=%h mis=%b required 00000123/1", pc_in, misaligned);
    end
    pc_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h8, 32'h100, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    ce = comb_q.pop_front();
    re = reg_q.pop_front();
    checks++;
    if (pc_q !== re.pc || branch_cnt !== re.cnt) begin
      errors++;
      $display("FAIL arst_resume pc_q=%h cnt=%h required %h/%h",
               pc_q, branch_cnt, re.pc, re.cnt);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      apply($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      ce = comb_q.pop_front();
      checks++;
      if (pc_in !== ce.pc || misaligned !== ce.mis) begin
        errors++;
        $display("FAIL b2b_comb[%0d] pc_in=%h mis=%b required %h/%b",
                 i, pc_in, misaligned, ce.pc, ce.mis);
      end
      @(posedge clk);
      #1;
      re = reg_q.pop_front();
      checks++;
      if (pc_q !== re.pc || branch_cnt !== re.cnt) begin
        errors++;
        $display("FAIL b2b_reg[%0d] pc_q=%h cnt=%h required %h/%h",
                 i, pc_q, branch_cnt, re.pc, re.cnt);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_pc   = '0;
    m_cnt  = '0;
    test_reset();
    test_comb_select();
    test_load_hold();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    checks++;
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain comb=%0d reg=%0d required 0/0",
               comb_q.size(), reg_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
